// File: rtl/onchip_mem_arbiter.sv
// Round-robin arbiter letting two Avalon-MM masters share one single-port on-chip RAM.
// One access per cycle; read data returns with fixed one-cycle latency via readdatavalid.
`timescale 1ns/1ps
module onchip_mem_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16,
    parameter int BE_W   = 2,
    parameter int DEPTH  = 15360
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    localparam logic [ADDR_W:0] DEPTH_W = DEPTH[ADDR_W:0];

    logic req0, req1, grant0, grant1, any_grant, sel;
    logic sel_read, sel_write, in_range;
    logic last_grant_q, last_grant_d;
    logic rd_valid_q, rd_valid_d;
    logic rd_owner_q, rd_owner_d;
    logic rd_oor_q, rd_oor_d;
    logic [DATA_W-1:0] rd_data;

    always_comb begin
        req0      = m0_read | m0_write;
        req1      = m1_read | m1_write;
        // On contention the master that was not granted last time wins.
        grant0    = req0 & (~req1 | last_grant_q);
        grant1    = req1 & (~req0 | ~last_grant_q);
        any_grant = grant0 | grant1;
        // With no grant, the mux stays on the last-granted master.
        sel       = grant1 | (~grant0 & last_grant_q);

        mem_address    = sel ? m1_address    : m0_address;
        mem_byteenable = sel ? m1_byteenable : m0_byteenable;
        mem_writedata  = sel ? m1_writedata  : m0_writedata;
        sel_read       = sel ? m1_read       : m0_read;
        sel_write      = sel ? m1_write      : m0_write;
        in_range       = ({1'b0, mem_address} < DEPTH_W);

        mem_write      = any_grant & sel_write;
        mem_chipselect = any_grant & in_range;
        mem_clken      = 1'b1;

        last_grant_d   = any_grant ? grant1 : last_grant_q;
        // A simultaneous write takes precedence; the read half is dropped.
        rd_valid_d     = any_grant & sel_read & ~sel_write;
        rd_owner_d     = rd_valid_d & sel;
        rd_oor_d       = rd_valid_d & ~in_range;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= 1'b1;
            rd_valid_q   <= 1'b0;
            rd_owner_q   <= 1'b0;
            rd_oor_q     <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            rd_valid_q   <= rd_valid_d;
            rd_owner_q   <= rd_owner_d;
            rd_oor_q     <= rd_oor_d;
        end
    end

    assign m0_waitrequest   = req0 & ~grant0;
    assign m1_waitrequest   = req1 & ~grant1;

    assign rd_data          = (rd_valid_q & ~rd_oor_q) ? mem_readdata : '0;
    assign m0_readdatavalid = rd_valid_q & ~rd_owner_q;
    assign m1_readdatavalid = rd_valid_q &  rd_owner_q;
    assign m0_readdata      = m0_readdatavalid ? rd_data : '0;
    assign m1_readdata      = m1_readdatavalid ? rd_data : '0;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench for onchip_mem_arbiter with a RAM model and a per-master read-data scoreboard.
`timescale 1ns/1ps
module tb_onchip_mem_arbiter;

    localparam int DEPTH = 15360;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [13:0] m0_address, m1_address;
    logic [1:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [15:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [15:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [13:0] mem_address;
    logic [1:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [15:0] mem_writedata, mem_readdata;

    onchip_mem_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                          input logic [1:0] be);
        merge = {be[1] ? d[15:8] : old[15:8], be[0] ? d[7:0] : old[7:0]};
    endfunction

    // RAM model: registered address, unregistered q.
    logic [15:0] ram [0:16383];
    logic [13:0] ram_addr_q;
    always @(posedge clk) begin
        if (mem_clken) begin
            ram_addr_q <= mem_address;
            if (mem_chipselect && mem_write)
                ram[mem_address] <= merge(ram[mem_address], mem_writedata, mem_byteenable);
        end
    end
    assign mem_readdata = ram[ram_addr_q];

    int pass_cnt = 0;
    int tot_cnt  = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tot_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    typedef struct { logic [15:0] data; int due; } exp_t;
    exp_t q0[$];
    exp_t q1[$];
    logic [15:0] ref_mem [0:16383];

    // Scoreboard: each expected read must arrive exactly at its due cycle, nothing else.
    always @(negedge clk) begin
        if (q0.size() > 0 && q0[0].due == cyc) begin
            chk("m0_rdvalid", m0_readdatavalid, 1);
            chk("m0_rdata", m0_readdata, q0[0].data);
            void'(q0.pop_front());
        end else if (m0_readdatavalid) chk("m0_rdvalid_unexpected", m0_readdatavalid, 0);
        if (q1.size() > 0 && q1[0].due == cyc) begin
            chk("m1_rdvalid", m1_readdatavalid, 1);
            chk("m1_rdata", m1_readdata, q1[0].data);
            void'(q1.pop_front());
        end else if (m1_readdatavalid) chk("m1_rdvalid_unexpected", m1_readdatavalid, 0);
    end

    task automatic drv(input int m, input logic rd, input logic wr, input logic [13:0] a,
                       input logic [1:0] be, input logic [15:0] d);
        if (m == 0) begin
            m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
        end else begin
            m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
        end
    endtask

    task automatic idle();
        drv(0, 0, 0, 14'd0, 2'b00, 16'h0);
        drv(1, 0, 0, 14'd0, 2'b00, 16'h0);
    endtask

    task automatic accept(input int m, input logic wr, input logic [13:0] a,
                          input logic [1:0] be, input logic [15:0] d);
        exp_t e;
        if (wr) begin
            if (int'(a) < DEPTH) ref_mem[a] = merge(ref_mem[a], d, be);
        end else begin
            e.data = (int'(a) < DEPTH) ? ref_mem[a] : 16'h0000;
            e.due  = cyc + 1;
            if (m == 0) q0.push_back(e); else q1.push_back(e);
        end
    endtask

    logic w0, w1, cs, mw;
    task automatic step();
        @(negedge clk);
        w0 = m0_waitrequest; w1 = m1_waitrequest; cs = mem_chipselect; mw = mem_write;
        if ((m0_read || m0_write) && !m0_waitrequest)
            accept(0, m0_write, m0_address, m0_byteenable, m0_writedata);
        if ((m1_read || m1_write) && !m1_waitrequest)
            accept(1, m1_write, m1_address, m1_byteenable, m1_writedata);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int a0, a1;
        reset_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_m0_rdvalid", m0_readdatavalid, 0);
        chk("rst_m1_rdvalid", m1_readdatavalid, 0);
        chk("rst_m0_rdata", m0_readdata, 0);
        chk("rst_cs", mem_chipselect, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_idle_wait0", m0_waitrequest, 0);
        drv(0, 1, 0, 14'd1, 2'b11, 16'h0);
        drv(1, 1, 0, 14'd2, 2'b11, 16'h0);
        #1;
        chk("rst_contend_wait0", m0_waitrequest, 0);
        chk("rst_contend_wait1", m1_waitrequest, 1);
        idle();
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Single write then read by m0
        drv(0, 0, 1, 14'h0010, 2'b11, 16'hA5C3); step(); chk("t1_wr_wait0", w0, 0);
        drv(0, 1, 0, 14'h0010, 2'b11, 16'h0);    step(); chk("t1_rd_wait0", w0, 0);
        idle(); step();

        // Byte lanes
        drv(0, 0, 1, 14'h0011, 2'b11, 16'hFFFF); step();
        drv(0, 0, 1, 14'h0011, 2'b10, 16'h1200); step();
        drv(0, 1, 0, 14'h0011, 2'b11, 16'h0);    step();
        idle(); step();
        chk("t2_ref_value", ref_mem[14'h0011], 16'h12FF);

        // Prefill; m1 last so m0 wins the first contention
        for (int i = 0; i < 4; i++) begin
            drv(0, 0, 1, 14'h0100 + 14'(i), 2'b11, 16'h1000 + 16'(i)); step();
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            drv(1, 0, 1, 14'h0200 + 14'(i), 2'b11, 16'h2000 + 16'(i)); step();
        end

        // Contention: both read continuously for 8 cycles
        a0 = 0; a1 = 0;
        for (int i = 0; i < 8; i++) begin
            drv(0, 1, 0, 14'h0100 + 14'(a0), 2'b11, 16'h0);
            drv(1, 1, 0, 14'h0200 + 14'(a1), 2'b11, 16'h0);
            step();
            chk("t3_wait0", w0, (i % 2 == 1) ? 1 : 0);
            chk("t3_wait1", w1, (i % 2 == 0) ? 1 : 0);
            if (!w0) a0++;
            if (!w1) a1++;
        end
        idle(); step(); step();

        // Out of range
        drv(1, 0, 1, 14'd15359, 2'b11, 16'hBEEF); step(); chk("t4_inrange_cs", cs, 1);
        drv(1, 0, 1, 14'd15360, 2'b11, 16'h1234); step();
        chk("t4_oor_wr_cs", cs, 0); chk("t4_oor_wr_wait", w1, 0);
        drv(1, 1, 0, 14'd15360, 2'b11, 16'h0);    step();
        chk("t4_oor_rd_cs", cs, 0); chk("t4_oor_rd_wait", w1, 0);
        drv(1, 1, 0, 14'd15359, 2'b11, 16'h0);    step();
        idle(); step();

        // Reset right after an accepted m1 read
        drv(1, 1, 0, 14'h0200, 2'b11, 16'h0); step();
        reset_n = 1'b0;
        void'(q1.pop_back());
        idle();
        @(negedge clk);
        chk("t5_rdvalid_suppressed", m1_readdatavalid, 0);
        drv(0, 1, 0, 14'h0101, 2'b11, 16'h0);
        drv(1, 1, 0, 14'h0201, 2'b11, 16'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        step(); chk("t5_post_wait0", w0, 0); chk("t5_post_wait1", w1, 1);
        drv(0, 0, 0, 14'd0, 2'b00, 16'h0);
        step(); chk("t5_m1_after", w1, 0);
        idle(); step(); step();

        // Read and write together: write wins
        drv(0, 1, 1, 14'h0020, 2'b11, 16'h0F0F); step();
        chk("t6_wait0", w0, 0); chk("t6_mem_write", mw, 1);
        idle(); step();
        drv(0, 1, 0, 14'h0020, 2'b11, 16'h0);    step();
        idle(); step(); step();
        chk("t6_ref_value", ref_mem[14'h0020], 16'h0F0F);

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
